// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the fabric configuration loader: FSM state
// encoding and the word-count helper used to size the shadow register.
package kfpga_config_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  // Number of stream words needed to cover a configuration vector,
  // rounded up so a partial last word still gets its own slot.
  function automatic int num_words(input int config_width, input int word_width);
    return (config_width + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/kfpga_config_loader.sv
// Fabric configuration loader. Collects NUM_WORDS stream words into a
// shadow register, verifies them against a trailing XOR checksum word and
// only then commits the whole vector to config_out in a single cycle.
// fabric_enable releases the core (its active-low reset) after a good load.
module kfpga_config_loader
  import kfpga_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = 2034,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    fabric_enable,
  output logic                    done,
  output logic                    error
);

  localparam int NUM_WORDS = num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   acc_q, acc_d;
  logic [SHADOW_W-1:0]     shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    fen_q, fen_d;
  logic                    accept;

  // Ready only while collecting; a pending load_start blocks acceptance so
  // the word cannot leak into the load that is being restarted.
  assign cfg_ready = ((state_q == LOAD) || (state_q == CHECK)) && !load_start;
  assign accept    = cfg_valid && cfg_ready;

  assign config_out    = config_q;
  assign fabric_enable = fen_q;
  assign done          = done_q;
  assign error         = error_q;

  // State register; reset abandons any load in progress immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers, all cleared by reset so no partial
  // configuration can survive an aborted load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      config_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      fen_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
      done_q   <= done_d;
      error_q  <= error_d;
      fen_q    <= fen_d;
    end
  end

  // Next-state and datapath updates; load_start overrides every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    config_d = config_q;
    done_d   = done_q;
    error_d  = error_q;
    fen_d    = fen_q;

    if (load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      acc_d   = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
      fen_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            // Shift right and insert at the top: after NUM_WORDS words the
            // first one received sits in the least-significant slot.
            shadow_d = {cfg_data, shadow_q[SHADOW_W-1:WORD_WIDTH]};
            acc_d    = acc_q ^ cfg_data;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            if (cfg_data == acc_q) begin
              // Padding above CONFIG_WIDTH was checksummed but is dropped here.
              config_d = shadow_q[CONFIG_WIDTH-1:0];
              done_d   = 1'b1;
              fen_d    = 1'b1;
              state_d  = DONE;
            end else begin
              error_d = 1'b1;
              fen_d   = 1'b0;
              state_d = ERROR;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR wait for load_start; stream input ignored.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Self-checking bench for kfpga_config_loader with CONFIG_WIDTH=10 and
// WORD_WIDTH=4 (three data words plus one checksum word per load).
module tb_kfpga_config_loader;

  localparam int CW = 10;
  localparam int WW = 4;
  localparam int NW = 3;

  logic          clock;
  logic          reset;
  logic          load_start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] config_out;
  logic          fabric_enable;
  logic          done;
  logic          error;

  kfpga_config_loader #(
    .CONFIG_WIDTH (CW),
    .WORD_WIDTH   (WW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_start    (load_start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .config_out    (config_out),
    .fabric_enable (fabric_enable),
    .done          (done),
    .error         (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: words collected for the current load, plus results.
  int            m_words[$];
  bit            m_active;
  logic [CW-1:0] m_cfg;
  bit            m_done, m_err, m_fen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit ls);
    return m_active && !ls && (m_words.size() <= NW);
  endfunction

  function automatic void model_reset();
    m_words.delete();
    m_active = 1'b0;
    m_cfg    = '0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_fen    = 1'b0;
  endfunction

  // Apply one rising edge of behaviour to the model.
  function automatic void model_clock(input bit ls, input bit v, input int d);
    int            x;
    logic [15:0]   full;
    if (ls) begin
      m_words.delete();
      m_active = 1'b1;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_fen    = 1'b0;
    end else if (v && model_ready(1'b0)) begin
      m_words.push_back(d);
      if (m_words.size() == NW + 1) begin
        x    = 0;
        full = '0;
        for (int k = 0; k < NW; k++) begin
          x    = x ^ m_words[k];
          full = full | (16'(m_words[k]) << (k * WW));
        end
        if (x == m_words[NW]) begin
          m_cfg  = full[CW-1:0];
          m_done = 1'b1;
          m_fen  = 1'b1;
        end else begin
          m_err = 1'b1;
          m_fen = 1'b0;
        end
        m_active = 1'b0;
      end
    end
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ".config_out"}, 32'(config_out), 32'(m_cfg));
    chk({where, ".done"}, 32'(done), 32'(m_done));
    chk({where, ".error"}, 32'(error), 32'(m_err));
    chk({where, ".fabric_enable"}, 32'(fabric_enable), 32'(m_fen));
  endtask

  // One clock cycle: drive at negedge, check ready, clock, check outputs.
  task automatic step(input bit ls, input bit v, input int d);
    @(negedge clock);
    load_start = ls;
    cfg_valid  = v;
    cfg_data   = WW'(d);
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'(model_ready(ls)));
    @(posedge clock);
    model_clock(ls, v, d);
    #1;
    check_outputs("cycle");
  endtask

  // Deliver one word after a random number of idle (valid-low) cycles.
  task automatic send_word(input int w);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, int'($urandom_range(0, 15)));
    step(1'b0, 1'b1, w);
  endtask

  task automatic send_load(input int w0, input int w1, input int w2, input int cs);
    step(1'b1, 1'b0, 0);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(cs);
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic async_reset(input string where);
    @(negedge clock);
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(where);
    chk({where, ".cfg_ready"}, 32'(cfg_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int w0, w1, w2, cs;
    reset      = 1'b0;
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    model_reset();

    // Reset state.
    async_reset("reset");
    chk("reset.config_out_const", 32'(config_out), 32'h000);

    // Valid words while idle are ignored.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, int'($urandom_range(0, 15)));

    // Good load.
    send_load(1, 2, 3, 0);
    chk("good.config_out_const", 32'(config_out), 32'h321);
    chk("good.done_const", 32'(done), 32'd1);
    chk("good.fen_const", 32'(fabric_enable), 32'd1);

    // Extra words in DONE are ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, int'($urandom_range(0, 15)));

    // Bad checksum keeps the old configuration.
    send_load(1, 2, 3, 15);
    chk("bad.error_const", 32'(error), 32'd1);
    chk("bad.fen_const", 32'(fabric_enable), 32'd0);
    chk("bad.config_out_const", 32'(config_out), 32'h321);

    // Restart after two words; the abandoned words must not be used.
    step(1'b1, 1'b0, 0);
    send_word(int'($urandom_range(0, 15)));
    send_word(int'($urandom_range(0, 15)));
    send_load(5, 0, 2, 7);
    chk("restart.config_out_const", 32'(config_out), 32'h205);
    chk("restart.done_const", 32'(done), 32'd1);

    // load_start while a word is offered: that word is not accepted.
    step(1'b1, 1'b1, 9);

    // Mid-load reset after two words.
    send_word(4);
    send_word(6);
    async_reset("midload");
    chk("midload.config_out_const", 32'(config_out), 32'h000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, int'($urandom_range(0, 15)));

    // Randomized loads with padding bits and random checksum correctness.
    for (int n = 0; n < 40; n++) begin
      w0 = int'($urandom_range(0, 15));
      w1 = int'($urandom_range(0, 15));
      w2 = int'($urandom_range(0, 15));
      cs = ($urandom_range(0, 1) == 1) ? (w0 ^ w1 ^ w2) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        step(1'b1, 1'b0, 0);
        send_word(int'($urandom_range(0, 15)));
      end
      send_load(w0, w1, w2, cs);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++)
        step(1'b0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kfpga_config_loader.md
KFPGA_CONFIG_LOADER -- requirements
Module: kfpga_config_loader

Interface
REQ-001 The block SHALL have a parameter CONFIG_WIDTH, default 2034, giving the width of the fabric configuration vector.
REQ-002 The block SHALL have a parameter WORD_WIDTH, default 32, giving the configuration stream word width.
REQ-003 Derived constant NUM_WORDS SHALL equal ceil(CONFIG_WIDTH/WORD_WIDTH); default 64.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port load_start, input, 1 bit: single-cycle pulse that begins a new load.
REQ-007 The block SHALL have port cfg_data, input, WORD_WIDTH bits: the configuration word.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: the block accepts a word this cycle.
REQ-010 The block SHALL have port config_out, output, CONFIG_WIDTH bits: the committed configuration driving the core.
REQ-011 The block SHALL have port fabric_enable, output, 1 bit: the core may run, i.e. the active-low core reset is released.
REQ-012 The block SHALL have port done, output, 1 bit: the last load committed successfully.
REQ-013 The block SHALL have port error, output, 1 bit: the last load failed its checksum.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, CHECK, DONE and ERROR.
REQ-015 A word SHALL be accepted when cfg_valid and cfg_ready are both 1 in the same cycle.
REQ-016 cfg_ready SHALL be 1 only in LOAD or CHECK while load_start is 0; this is the only combinational path.
REQ-017 load_start in any state SHALL, next cycle: enter LOAD; clear the word counter and XOR accumulator; clear done, error and fabric_enable.
REQ-018 In LOAD, each accepted word SHALL shift the shadow register (NUM_WORDS*WORD_WIDTH bits) right by WORD_WIDTH, insert the word at the top, XOR the word into the accumulator and increment the counter.
REQ-019 Words SHALL arrive least-significant first, so that word k lands at shadow bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-020 When the NUM_WORDS-th word is accepted, the FSM SHALL move to CHECK.
REQ-021 In CHECK, the next accepted word is the checksum.
REQ-022 If the checksum equals the accumulator, the next cycle SHALL give: config_out = shadow[CONFIG_WIDTH-1:0], done=1, fabric_enable=1, and state DONE.
REQ-023 If the checksum does not equal the accumulator, the next cycle SHALL give: error=1, fabric_enable=0, config_out unchanged, and state ERROR.
REQ-024 Padding bits of the last word above CONFIG_WIDTH SHALL be discarded from config_out but SHALL be included in the checksum.
REQ-025 config_out SHALL change only on a successful commit, and SHALL be atomic (all bits in the same cycle).
REQ-026 In IDLE, DONE and ERROR, cfg_valid SHALL be ignored.
REQ-027 DONE and ERROR SHALL hold until load_start or reset.
REQ-028 Gaps in cfg_valid SHALL stall the counter and shadow register with no loss of data.

Reset
REQ-029 Reset SHALL act asynchronously and set: state IDLE; counter, accumulator and shadow = 0; config_out = 0; fabric_enable, done, error and cfg_ready = 0.
REQ-030 Reset asserted mid-load SHALL abandon the load immediately; no partial commit is permitted.
REQ-031 After reset deasserts, the block SHALL take no action until load_start.

Structure
REQ-032 A shared package kfpga_config_pkg SHALL hold the FSM state encoding and the NUM_WORDS ceiling-division function.
REQ-033 The counter width SHALL be clog2(NUM_WORDS+1).
REQ-034 The design SHALL be a single module with no sub-modules.
REQ-035 The core top SHALL instantiate the loader; fabric_enable SHALL drive the core's nreset, and config_out SHALL drive its config_in.

Verification (CONFIG_WIDTH=10, WORD_WIDTH=4, so NUM_WORDS=3)
REQ-036 Reset scenario: assert reset -> config_out=0x000; done, error, fabric_enable and cfg_ready all 0.
REQ-037 Good-load scenario: load_start, then words 0x1, 0x2, 0x3, then checksum 0x0 -> one cycle after the checksum: config_out=0x321, done=1, fabric_enable=1.
REQ-038 Bad-checksum scenario: after REQ-037, reload the same words with checksum 0xF -> error=1, fabric_enable=0, config_out stays 0x321.
REQ-039 Backpressure-and-restart scenario: random cfg_valid gaps; a load_start after 2 words, then 0x5, 0x0, 0x2 with checksum 0x7 -> config_out=0x205.
REQ-040 Idle and mid-load reset scenario: cfg_valid in IDLE -> cfg_ready=0 and no state change; reset asserted after 2 words -> all outputs 0 in the same cycle.
